// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace buffer.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  localparam int unsigned TRACE_XLEN = 32;
  localparam int unsigned TRACE_RD_W = 5;

  // Default entry layout; the top re-derives it from its own parameters.
  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_RD_W-1:0] rd;
    logic [TRACE_XLEN-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_buffer_ring.sv
// Circular entry store with head/tail pointers and overwrite-on-full.
module trace_ring
  import wb_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter type         entry_t = trace_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  entry_t                       wdata,
  output entry_t                       rdata_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overwrite_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t         mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic           full;

  assign full        = (count == CW'(DEPTH));
  assign overwrite_c = push && full;
  assign rdata_c     = mem[head];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[tail] <= wdata;
    end
  end

  // Pointer and occupancy tracking; a full push drops the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (push) begin
      tail <= tail + PW'(1);
      if (full) begin
        head <= head + PW'(1);
      end else begin
        count <= count + CW'(1);
      end
    end else if (pop) begin
      head  <= head + PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Filtered writeback capture with PC trigger, STOP/WRAP modes and drain port.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned REGS  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_valid,
  input  logic [XLEN-1:0]              wb_pc,
  input  logic [$clog2(REGS)-1:0]      wb_rd,
  input  logic [XLEN-1:0]              wb_data,
  input  logic [REGS-1:0]              cfg_reg_mask,
  input  logic                         cfg_mode,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_post,
  input  logic                         trig_en,
  input  logic [XLEN-1:0]              trig_pc,
  input  logic                         arm,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [XLEN-1:0]              rd_pc,
  output logic [$clog2(REGS)-1:0]      rd_rd,
  output logic [XLEN-1:0]              rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         triggered,
  output logic                         overflow,
  output logic                         done
);

  localparam int unsigned RW = $clog2(REGS);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } entry_t;

  trace_state_t    state;
  logic            mode_q;
  logic            trig_en_q;
  logic [XLEN-1:0] trig_pc_q;
  logic [REGS-1:0] mask_q;
  logic [CW-1:0]   post_cnt;

  logic   hit_c;
  logic   fire_c;
  logic   start_c;
  logic   push_c;
  logic   pop_c;
  logic   overwrite_c;
  entry_t wentry;
  entry_t head_c;

  assign hit_c   = wb_valid && mask_q[wb_rd];
  assign fire_c  = !trig_en_q || (wb_valid && (wb_pc == trig_pc_q));
  assign start_c = arm && ((state == IDLE) || (state == DONE));
  assign pop_c   = rd_valid && rd_ready;
  assign wentry  = '{pc: wb_pc, rd: wb_rd, data: wb_data};

  assign done     = (state == DONE);
  assign rd_valid = done && (count != '0);
  assign rd_pc    = rd_valid ? head_c.pc   : '0;
  assign rd_rd    = rd_valid ? head_c.rd   : '0;
  assign rd_data  = rd_valid ? head_c.data : '0;

  // Capture gating: WRAP records while armed, STOP only from the trigger on.
  always_comb begin
    push_c = 1'b0;
    case (state)
      ARMED:   push_c = hit_c && ((mode_q == MODE_WRAP) || fire_c);
      POST:    push_c = hit_c;
      default: push_c = 1'b0;
    endcase
  end

  // Run-control FSM with latched configuration and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_STOP;
      trig_en_q <= 1'b0;
      trig_pc_q <= '0;
      mask_q    <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else if (start_c) begin
      state     <= ARMED;
      mode_q    <= cfg_mode;
      trig_en_q <= trig_en;
      trig_pc_q <= trig_pc;
      mask_q    <= cfg_reg_mask;
      post_cnt  <= cfg_post;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (overwrite_c) begin
        overflow <= 1'b1;
      end
      case (state)
        ARMED: begin
          if (fire_c) begin
            triggered <= 1'b1;
            state     <= ((mode_q == MODE_WRAP) && (post_cnt == '0)) ? DONE : POST;
          end
        end
        POST: begin
          if (hit_c) begin
            if (mode_q == MODE_STOP) begin
              if (count == CW'(DEPTH - 1)) begin
                state <= DONE;
              end
            end else begin
              post_cnt <= post_cnt - CW'(1);
              if (post_cnt == CW'(1)) begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          if (pop_c && (count == CW'(1))) begin
            state <= IDLE;
          end
        end
        default: state <= state;
      endcase
    end
  end

  trace_ring #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_c),
    .push        (push_c),
    .pop         (pop_c),
    .wdata       (wentry),
    .rdata_c     (head_c),
    .count       (count),
    .overwrite_c (overwrite_c)
  );

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int REGS  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] cfg_reg_mask = '0;
  logic        cfg_mode = 1'b0;
  logic [3:0]  cfg_post = '0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        arm = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_pc;
  logic [4:0]  rd_rd;
  logic [31:0] rd_data;
  logic [3:0]  count;
  logic        triggered;
  logic        overflow;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  wb_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .REGS(REGS)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_data(wb_data), .cfg_reg_mask(cfg_reg_mask), .cfg_mode(cfg_mode),
    .cfg_post(cfg_post), .trig_en(trig_en), .trig_pc(trig_pc), .arm(arm),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_rd(rd_rd),
    .rd_data(rd_data), .count(count), .triggered(triggered),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: captured entries as a queue, phase as a small integer.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_phase = 0;  // 0 idle, 1 waiting for trigger, 2 post-trigger, 3 draining
  bit          m_trig = 0;
  bit          m_ovf = 0;
  bit          m_mode = 0;
  bit          m_te = 0;
  logic [31:0] m_tpc = '0;
  logic [31:0] m_mask = '0;
  int          m_left = 0;

  task automatic m_store();
    ent_t e;
    e.pc = wb_pc; e.rd = wb_rd; e.data = wb_data;
    if (q.size() == DEPTH) begin
      void'(q.pop_front());
      m_ovf = 1;
    end
    q.push_back(e);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_phase = 0; m_trig = 0; m_ovf = 0; m_left = 0;
    end else begin
      bit hit, fire;
      hit  = wb_valid && m_mask[wb_rd];
      fire = !m_te || (wb_valid && wb_pc == m_tpc);
      if (arm && (m_phase == 0 || m_phase == 3)) begin
        q.delete();
        m_trig = 0; m_ovf = 0;
        m_mode = cfg_mode; m_te = trig_en; m_tpc = trig_pc;
        m_mask = cfg_reg_mask; m_left = int'(cfg_post);
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (hit && (m_mode || fire)) m_store();
        if (fire) begin
          m_trig = 1;
          m_phase = (m_mode && m_left == 0) ? 3 : 2;
        end
      end else if (m_phase == 2) begin
        if (hit) begin
          m_store();
          if (!m_mode) begin
            if (q.size() == DEPTH) m_phase = 3;
          end else begin
            m_left--;
            if (m_left == 0) m_phase = 3;
          end
        end
      end else if (m_phase == 3) begin
        if (q.size() > 0 && rd_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) m_phase = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("count", 64'(count), 64'(q.size()));
    chk("done", 64'(done), 64'(m_phase == 3));
    chk("rd_valid", 64'(rd_valid), 64'(m_phase == 3 && q.size() != 0));
    chk("triggered", 64'(triggered), 64'(m_trig));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (m_phase == 3 && q.size() != 0) begin
      chk("rd_pc", 64'(rd_pc), 64'(q[0].pc));
      chk("rd_rd", 64'(rd_rd), 64'(q[0].rd));
      chk("rd_data", 64'(rd_data), 64'(q[0].data));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1; wb_pc = pc; wb_rd = rd; wb_data = d;
    next_cycle();
    wb_valid = 1'b0;
  endtask

  task automatic do_arm(input logic mode, input logic te, input logic [31:0] tpc,
                        input logic [31:0] mask, input logic [3:0] post);
    cfg_mode = mode; trig_en = te; trig_pc = tpc; cfg_reg_mask = mask; cfg_post = post;
    arm = 1'b1;
    next_cycle();
    arm = 1'b0;
  endtask

  // Drain with rd_ready held high, checking literal data first..first+n-1.
  task automatic drain_data(input int first, input int n);
    rd_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("drain_valid", 64'(rd_valid), 64'd1);
      chk("drain_data", 64'(rd_data), 64'(first + k));
      next_cycle();
    end
    rd_ready = 1'b0;
    @(negedge clk);
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_idle", 64'(done), 64'd0);
    chk("trig_held", 64'(triggered), 64'd1);
    next_cycle();
  endtask

  initial begin
    logic [31:0] got[$];
    bit          pat[4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // STOP, immediate trigger, x6 only; the 8th x6 write fills the buffer.
    do_arm(1'b0, 1'b0, 32'h0, 32'h1 << 6, 4'd0);
    for (int i = 1; i <= 12; i++) wb(32'h1000 + 32'(4 * i), 5'd6, 32'(i));
    for (int i = 1; i <= 3; i++) wb(32'h2000 + 32'(4 * i), 5'd5, 32'(100 + i));
    @(negedge clk);
    chk("t1_count", 64'(count), 64'd8);
    chk("t1_done", 64'(done), 64'd1);
    next_cycle();
    drain_data(1, 8);

    // STOP, PC trigger at 0x40; the 0x30 write precedes the trigger.
    do_arm(1'b0, 1'b1, 32'h40, 32'h1 << 6, 4'd0);
    wb(32'h30, 5'd6, 32'hA0);
    wb(32'h40, 5'd6, 32'hA1);
    wb(32'h44, 5'd6, 32'hA2);
    @(negedge clk);
    chk("t2_triggered", 64'(triggered), 64'd1);
    chk("t2_count", 64'(count), 64'd2);
    next_cycle();
    for (int i = 3; i <= 8; i++) wb(32'h40 + 32'(4 * i), 5'd6, 32'hA0 + 32'(i));
    @(negedge clk);
    chk("t2_first_pc", 64'(rd_pc), 64'h40);
    chk("t2_first_rd", 64'(rd_rd), 64'd6);
    chk("t2_done", 64'(done), 64'd1);
    next_cycle();

    // Backpressured drain with rd_ready pattern 1,0,0,1.
    for (int c = 0; c < 64 && done; c++) begin
      rd_ready = pat[c % 4];
      @(negedge clk);
      if (rd_valid && rd_ready) got.push_back(rd_data);
      next_cycle();
    end
    rd_ready = 1'b0;
    chk("t4_drain_timeout", 64'(done), 64'd0);
    chk("t4_pops", 64'(got.size()), 64'd8);
    for (int k = 0; k < 8 && k < got.size(); k++)
      chk("t4_pop_data", 64'(got[k]), 64'hA1 + 64'(k));

    // WRAP, post=2, trigger on the 10th hit; keeps the last 8 hits.
    do_arm(1'b1, 1'b1, 32'h100 + 32'd40, 32'h1 << 6, 4'd2);
    for (int i = 1; i <= 12; i++) begin
      wb(32'h100 + 32'(4 * i), 5'd6, 32'(i));
      if (i == 3) wb(32'h900, 5'd7, 32'hFF);
    end
    @(negedge clk);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_count", 64'(count), 64'd8);
    next_cycle();
    drain_data(5, 8);

    // Reset in the middle of POST with three entries held.
    do_arm(1'b0, 1'b0, 32'h0, 32'h1 << 6, 4'd0);
    for (int i = 1; i <= 3; i++) wb(32'h500 + 32'(4 * i), 5'd6, 32'(i));
    @(negedge clk);
    chk("t5_count_pre", 64'(count), 64'd3);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("t5_rst_count", 64'(count), 64'd0);
    chk("t5_rst_trig", 64'(triggered), 64'd0);
    chk("t5_rst_valid", 64'(rd_valid), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // WRAP with post=0; an arm pulse while waiting must change nothing.
    do_arm(1'b1, 1'b1, 32'hDEAD_0000, 32'h1 << 3, 4'd0);
    @(negedge clk);
    chk("t5_rearm_count", 64'(count), 64'd0);
    next_cycle();
    wb(32'h600, 5'd3, 32'h31);
    wb(32'h604, 5'd3, 32'h32);
    do_arm(1'b0, 1'b0, 32'h0, 32'h0, 4'd5);
    @(negedge clk);
    chk("t6_count", 64'(count), 64'd2);
    chk("t6_trig", 64'(triggered), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    next_cycle();
    wb(32'hDEAD_0000, 5'd3, 32'h33);
    @(negedge clk);
    chk("t6_done_now", 64'(done), 64'd1);
    chk("t6_count3", 64'(count), 64'd3);
    next_cycle();
    drain_data(32'h31, 3);

    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
